// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Loader state encoding plus the image length rule.
package mips_pkg;

  localparam int WORD_W      = 32;
  localparam int IMEM_ADDR_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    DONE,
    ERROR
  } ld_state_e;

  // A usable image holds between one word and the whole memory.
  function automatic logic len_ok(
    input logic [15:0] n,
    input int          aw
  );
    return (n != 16'd0) &&
           ({16'd0, n} <= (32'd1 << aw));
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Boot byte stream plus instruction-memory write port.
// master = host/memory side, slave = loader.
import mips_pkg::*;

interface imem_loader_if #(
  parameter int ADDR_W = IMEM_ADDR_W
);

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [WORD_W-1:0] mem_datain;
  logic              mem_write;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  mem_address,
    input  mem_datain,
    input  mem_write
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output mem_address,
    output mem_datain,
    output mem_write
  );

endinterface

// File: rtl/imem_word_packer.sv
// Packs a big-endian byte stream into 32-bit words.
// Emits each word with a one-cycle valid after its 4th byte.
import mips_pkg::*;

module imem_word_packer (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              byte_en_i,
  input  logic [7:0]        byte_i,
  output logic              last_o,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o
);

  logic [1:0]        cnt_q, cnt_d;
  logic [23:0]       sh_q, sh_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              vld_q, vld_d;

  assign last_o       = byte_en_i && (cnt_q == 2'd3);
  assign word_o       = word_q;
  assign word_valid_o = vld_q;

  always_comb begin
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    word_d = word_q;
    vld_d  = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
      sh_d  = '0;
    end else if (byte_en_i) begin
      cnt_d = cnt_q + 2'd1;
      sh_d  = {sh_q[15:0], byte_i};
      if (last_o) begin
        word_d = {sh_q, byte_i};
        vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sh_q   <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      word_q <= word_d;
      vld_q  <= vld_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-link byte stream to instruction memory writer.
// Holds the CPU until a checksum-verified image is resident.
import mips_pkg::*;

module imem_loader #(
  parameter int                ADDR_W    = IMEM_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         error
);

  ld_state_e         state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       wcnt_q, wcnt_d;
  logic [7:0]        chk_q, chk_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ready, acc, clr;
  logic              last, wvld;
  logic [WORD_W-1:0] word;
  logic [15:0]       len_full;

  assign ready = (state_q == LEN_HI) ||
                 (state_q == LEN_LO) ||
                 (state_q == DATA)   ||
                 (state_q == CHECK);
  assign acc      = bus.byte_valid && ready;
  assign len_full = {len_q[15:8], bus.byte_data};

  imem_word_packer u_pack (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (clr),
    .byte_en_i    (acc && (state_q == DATA)),
    .byte_i       (bus.byte_data),
    .last_o       (last),
    .word_o       (word),
    .word_valid_o (wvld)
  );

  assign bus.byte_ready  = ready;
  assign bus.mem_address = addr_q;
  assign bus.mem_datain  = word;
  assign bus.mem_write   = wvld;
  assign cpu_hold        = (state_q != DONE);
  assign done            = (state_q == DONE);
  assign error           = (state_q == ERROR);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    chk_d   = chk_q;
    addr_d  = addr_q;
    clr     = 1'b0;
    // Address advances the cycle after each strobe.
    if (wvld) addr_d = addr_q + ADDR_W'(1);
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = LEN_HI;
          clr     = 1'b1;
          len_d   = '0;
          wcnt_d  = '0;
          chk_d   = '0;
          addr_d  = BASE_ADDR;
        end
      end
      LEN_HI: begin
        if (acc) begin
          len_d   = {bus.byte_data, 8'h00};
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (acc) begin
          len_d   = len_full;
          state_d = len_ok(len_full, ADDR_W) ? DATA : ERROR;
        end
      end
      DATA: begin
        if (acc) begin
          chk_d = chk_q ^ bus.byte_data;
          if (last) begin
            wcnt_d = wcnt_q + 16'd1;
            if (wcnt_q == len_q - 16'd1) state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (acc) begin
          state_d = (bus.byte_data == chk_q) ? DONE : ERROR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      chk_q   <= '0;
      addr_q  <= BASE_ADDR;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      chk_q   <= chk_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench: two loaders (base 0 and base 0x3FF) fed the same
// stream, compared every cycle against a byte-count reference model.
module tb_imem_loader;

  localparam logic [9:0] B1 = 10'h3FF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       hold0, done0, err0;
  logic       hold1, done1, err1;
  logic       clr_req = 1'b0;

  int checks = 0;
  int errors = 0;

  imem_loader_if #(.ADDR_W(10)) bus0 ();
  imem_loader_if #(.ADDR_W(10)) bus1 ();

  assign bus0.byte_valid = valid;
  assign bus0.byte_data  = data;
  assign bus1.byte_valid = valid;
  assign bus1.byte_data  = data;

  imem_loader #(.ADDR_W(10), .BASE_ADDR(10'h000)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus0),
    .cpu_hold(hold0), .done(done0), .error(err0)
  );

  imem_loader #(.ADDR_W(10), .BASE_ADDR(B1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus1),
    .cpu_hold(hold1), .done(done1), .error(err1)
  );

  always #5 clk = ~clk;

  // Observed memory images and write counts.
  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [1024];
  int wc0 = 0;
  int wc1 = 0;

  always @(posedge clk) begin
    if (clr_req) begin
      wc0 <= 0;
      wc1 <= 0;
    end else begin
      if (bus0.mem_write) begin
        mem0[bus0.mem_address] <= bus0.mem_datain;
        wc0 <= wc0 + 1;
      end
      if (bus1.mem_write) begin
        mem1[bus1.mem_address] <= bus1.mem_datain;
        wc1 <= wc1 + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a session is just "bytes accepted so far".
  bit          armed = 0;
  bit          m_run = 0, m_done = 0, m_err = 0, m_wr = 0;
  int          m_k = 0, m_n = 0;
  logic [7:0]  m_x = 8'h00;
  logic [31:0] m_word = 32'h0, m_wdata = 32'h0;
  logic [9:0]  m_cnt = 10'h0;

  task automatic model_step();
    if (!rst_n) begin
      m_run = 0; m_done = 0; m_err = 0; m_wr = 0;
      m_cnt = 10'h0; m_k = 0; m_x = 8'h00;
    end else begin
      if (m_wr) m_cnt = m_cnt + 10'd1;
      m_wr = 0;
      if (!m_run) begin
        if (start) begin
          m_run = 1; m_done = 0; m_err = 0;
          m_k = 0; m_x = 8'h00; m_cnt = 10'h0;
        end
      end else if (valid) begin
        if (m_k == 0) m_n = int'(data) * 256;
        else if (m_k == 1) begin
          m_n = m_n + int'(data);
          if (m_n < 1 || m_n > 1024) begin
            m_run = 0; m_err = 1;
          end
        end else if (m_k < 2 + 4 * m_n) begin
          m_x = m_x ^ data;
          m_word = {m_word[23:0], data};
          if ((m_k - 2) % 4 == 3) begin
            m_wr = 1; m_wdata = m_word;
          end
        end else begin
          m_run = 0;
          if (data == m_x) m_done = 1;
          else m_err = 1;
        end
        m_k++;
      end
    end
  endtask

  task automatic compare();
    chk("ready0", 32'(bus0.byte_ready), 32'(m_run));
    chk("ready1", 32'(bus1.byte_ready), 32'(m_run));
    chk("write0", 32'(bus0.mem_write), 32'(m_wr));
    chk("write1", 32'(bus1.mem_write), 32'(m_wr));
    chk("addr0", 32'(bus0.mem_address), 32'(m_cnt));
    chk("addr1", 32'(bus1.mem_address), 32'(10'(B1 + m_cnt)));
    if (m_wr) begin
      chk("data0", bus0.mem_datain, m_wdata);
      chk("data1", bus1.mem_datain, m_wdata);
    end
    chk("hold0", 32'(hold0), 32'(!m_done));
    chk("hold1", 32'(hold1), 32'(!m_done));
    chk("done0", 32'(done0), 32'(m_done));
    chk("done1", 32'(done1), 32'(m_done));
    chk("err0", 32'(err0), 32'(m_err));
    chk("err1", 32'(err1), 32'(m_err));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      armed = 1;
      @(negedge clk);
      if (armed) compare();
    end
  end

  // Stimulus helpers; all start and end right after a negedge.
  logic [31:0] img [$];
  logic [7:0]  last_chk;

  task automatic put(input logic [7:0] b, input int gapmax,
                     input bit noisy);
    int g;
    g = (gapmax > 0) ? $urandom_range(gapmax, 0) : 0;
    repeat (g) begin
      valid = 1'b0;
      data  = 8'($urandom);
      start = noisy && ($urandom_range(3, 0) == 0);
      @(negedge clk);
    end
    valid = 1'b1;
    data  = b;
    start = noisy && ($urandom_range(3, 0) == 0);
    @(negedge clk);
    valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic idle(input int n, input bit junk);
    repeat (n) begin
      valid = junk ? 1'($urandom) : 1'b0;
      data  = 8'($urandom);
      @(negedge clk);
    end
    valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clr_counts();
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
  endtask

  task automatic send_img(input int n, input bit bad, input int gap,
                          input bit noisy, input logic [7:0] force_chk,
                          input bit use_force);
    logic [15:0] nn;
    logic [7:0]  x;
    logic [31:0] w;
    nn = 16'(n);
    x  = 8'h00;
    put(nn[15:8], gap, noisy);
    put(nn[7:0], gap, noisy);
    for (int i = 0; i < n; i++) begin
      w = img[i];
      for (int b = 3; b >= 0; b--) begin
        x = x ^ w[8*b +: 8];
        put(w[8*b +: 8], gap, noisy);
      end
    end
    last_chk = x;
    if (use_force) put(force_chk, gap, noisy);
    else if (bad) put(x ^ 8'($urandom_range(255, 1)), gap, noisy);
    else put(x, gap, noisy);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    // Reset state.
    chk("rst_ready", 32'(bus0.byte_ready), 32'd0);
    chk("rst_write", 32'(bus0.mem_write), 32'd0);
    chk("rst_addr0", 32'(bus0.mem_address), 32'h000);
    chk("rst_addr1", 32'(bus1.mem_address), 32'h3FF);
    chk("rst_datain", bus0.mem_datain, 32'h0);
    chk("rst_hold", 32'(hold0), 32'd1);
    chk("rst_flags", {30'd0, done0, err0}, 32'd0);
    rst_n = 1'b1;
    idle(4, 1);
    chk("idle_ready", 32'(bus0.byte_ready), 32'd0);

    // Two-word reference image.
    img = '{32'h20080005, 32'hAC010004};
    clr_counts();
    pulse_start();
    send_img(2, 0, 0, 0, 8'h00, 0);
    idle(3, 0);
    chk("t1_chk", 32'(last_chk), 32'h84);
    chk("t1_done", 32'(done0), 32'd1);
    chk("t1_hold", 32'(hold0), 32'd0);
    chk("t1_err", 32'(err0), 32'd0);
    chk("t1_wc", 32'(wc0), 32'd2);
    chk("t1_m0", mem0[0], 32'h20080005);
    chk("t1_m1", mem0[1], 32'hAC010004);
    chk("t4_m3ff", mem1[10'h3FF], 32'h20080005);
    chk("t4_m000", mem1[0], 32'hAC010004);
    chk("t4_done", 32'(done1), 32'd1);
    chk("model_done", 32'(m_done), 32'd1);

    // Bad checksums 0x00 and 0x89.
    for (int k = 0; k < 2; k++) begin
      clr_counts();
      pulse_start();
      send_img(2, 0, 0, 0, (k == 0) ? 8'h00 : 8'h89, 1);
      idle(3, 0);
      chk("t2_err", 32'(err0), 32'd1);
      chk("t2_done", 32'(done0), 32'd0);
      chk("t2_hold", 32'(hold0), 32'd1);
      chk("t2_wc", 32'(wc0), 32'd2);
    end

    // Length 0 and 0x0401.
    clr_counts();
    pulse_start();
    put(8'h00, 0, 0);
    put(8'h00, 0, 0);
    idle(3, 0);
    chk("t3_len0_err", 32'(err0), 32'd1);
    pulse_start();
    put(8'h04, 0, 0);
    put(8'h01, 0, 0);
    idle(3, 0);
    chk("t3_len401_err", 32'(err0), 32'd1);
    chk("t3_wc", 32'(wc0), 32'd0);

    // Full-memory image.
    img.delete();
    for (int i = 0; i < 1024; i++) img.push_back($urandom);
    clr_counts();
    pulse_start();
    send_img(1024, 0, 0, 0, 8'h00, 0);
    idle(3, 0);
    chk("full_done", 32'(done0), 32'd1);
    chk("full_wc", 32'(wc0), 32'd1024);
    chk("full_m0", mem0[0], img[0]);
    chk("full_m3ff", mem0[10'h3FF], img[1023]);
    chk("full_b1_first", mem1[10'h3FF], img[0]);
    chk("full_b1_last", mem1[10'h3FE], img[1023]);

    // Reset after six data bytes.
    img = '{32'h20080005, 32'hAC010004};
    clr_counts();
    pulse_start();
    put(8'h00, 0, 0);
    put(8'h02, 0, 0);
    put(8'h20, 0, 0);
    put(8'h08, 0, 0);
    put(8'h00, 0, 0);
    put(8'h05, 0, 0);
    put(8'hAC, 0, 0);
    put(8'h01, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_ready", 32'(bus0.byte_ready), 32'd0);
    chk("t5_addr", 32'(bus0.mem_address), 32'h000);
    chk("t5_hold", 32'(hold0), 32'd1);
    chk("t5_flags", {30'd0, done0, err0}, 32'd0);
    rst_n = 1'b1;
    idle(6, 1);
    chk("t5_wc", 32'(wc0), 32'd1);
    chk("t5_m0", mem0[0], 32'h20080005);
    chk("t5_idle_ready", 32'(bus0.byte_ready), 32'd0);

    // Gaps plus stray start pulses mid-load.
    clr_counts();
    pulse_start();
    send_img(2, 0, 3, 1, 8'h00, 0);
    idle(3, 0);
    chk("t6_done", 32'(done0), 32'd1);
    chk("t6_wc", 32'(wc0), 32'd2);
    chk("t6_m0", mem0[0], 32'h20080005);
    chk("t6_m1", mem0[1], 32'hAC010004);

    // Randomized sessions.
    for (int r = 0; r < 16; r++) begin
      int n;
      n = $urandom_range(6, 1);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom);
      pulse_start();
      if ($urandom_range(7, 0) == 0) begin
        n = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(65535, 1025);
        put(8'(n >> 8), 2, 1);
        put(8'(n), 2, 1);
      end else begin
        send_img(n, ($urandom_range(3, 0) == 0), 3, 1, 8'h00, 0);
      end
      idle(3, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
